shift_issue_stage: RTL and testbench

Issue stage for the 16-bit barrel shifter in the execute path: decoded SLL/SRA/ROR instructions enter here, get operand forwarding resolved and are held in a two-entry elastic buffer. The buffer drives the shifter's data, amount and mode inputs from registers. A valid/ready handshake isolates decode from back-pressure in execute. Non-shift opcodes are accepted and discarded so decode never stalls on them.

---
 rtl/shift_issue_stage.sv | 137 +++++++++++++
 tb/tb_shift_issue_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// Issue stage for the 16-bit barrel shifter: operand forwarding plus a registered
// head/skid elastic buffer. Define SHIFT_FWD_EN to compile in the EX/MEM and MEM/WB forwarding muxes.
module shift_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [3:0]  in_rs_idx,
  input  logic [15:0] in_rs_data,
  input  logic [3:0]  in_imm,
  input  logic [3:0]  in_rd,
  input  logic        exm_wr_en,
  input  logic [3:0]  exm_rd,
  input  logic [15:0] exm_data,
  input  logic        mwb_wr_en,
  input  logic [3:0]  mwb_rd,
  input  logic [15:0] mwb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] shift_in,
  output logic [3:0]  shift_val,
  output logic [1:0]  shift_mode,
  output logic [3:0]  out_rd
);

  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  amt;
    logic [1:0]  mode;
    logic [3:0]  rd;
  } entry_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic [1:0] mode_of(input logic [3:0] op);
    logic [1:0] m;
    case (op)
      OP_SLL:  m = 2'b00;
      OP_SRA:  m = 2'b01;
      OP_ROR:  m = 2'b10;
      default: m = 2'b00;
    endcase
    return m;
  endfunction

  entry_t      head_r, skid_r, head_nxt_s, skid_nxt_s, new_entry_s;
  logic        head_valid_r, skid_valid_r, in_ready_r;
  logic        head_valid_nxt_s, skid_valid_nxt_s;
  logic        store_s, consume_s;
  logic [15:0] operand_s;

  // Operand selection at the accept edge; EX/MEM has priority over MEM/WB, r0 is never forwarded
`ifdef SHIFT_FWD_EN
  always_comb begin
    operand_s = in_rs_data;
    if (exm_wr_en && (exm_rd == in_rs_idx) && (in_rs_idx != 4'h0)) begin
      operand_s = exm_data;
    end else if (mwb_wr_en && (mwb_rd == in_rs_idx) && (in_rs_idx != 4'h0)) begin
      operand_s = mwb_data;
    end else begin
      operand_s = in_rs_data;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{exm_wr_en, exm_rd, exm_data, mwb_wr_en, mwb_rd, mwb_data, in_rs_idx};
  assign operand_s = in_rs_data;
`endif

  assign new_entry_s = '{data: operand_s, amt: in_imm, mode: mode_of(in_opcode), rd: in_rd};
  assign store_s     = in_valid && in_ready_r && is_shift(in_opcode);
  assign consume_s   = head_valid_r && out_ready;

  // Next-state for head/skid; in_ready tracks the registered skid, so a store never meets a full skid
  always_comb begin
    head_nxt_s       = head_r;
    skid_nxt_s       = skid_r;
    head_valid_nxt_s = head_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      head_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else begin
      if (consume_s && skid_valid_r) begin
        head_nxt_s       = skid_r;
        head_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else if (consume_s) begin
        head_valid_nxt_s = 1'b0;
      end else begin
        head_valid_nxt_s = head_valid_r;
      end
      if (store_s && !head_valid_nxt_s) begin
        head_nxt_s       = new_entry_s;
        head_valid_nxt_s = 1'b1;
      end else if (store_s) begin
        skid_nxt_s       = new_entry_s;
        skid_valid_nxt_s = 1'b1;
      end else begin
        skid_valid_nxt_s = skid_valid_nxt_s;
      end
    end
  end

  // Buffer state and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r       <= '0;
      skid_r       <= '0;
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      head_r       <= head_nxt_s;
      skid_r       <= skid_nxt_s;
      head_valid_r <= head_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = head_valid_r;
  assign shift_in   = head_r.data;
  assign shift_val  = head_r.amt;
  assign shift_mode = head_r.mode;
  assign out_rd     = head_r.rd;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed, table-driven bench for shift_issue_stage; expected operands follow SHIFT_FWD_EN.
module tb_shift_issue_stage;

`ifdef SHIFT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [3:0]  in_opcode, in_rs_idx, in_imm, in_rd, exm_rd, mwb_rd, shift_val, out_rd;
  logic [15:0] in_rs_data, exm_data, mwb_data, shift_in;
  logic        exm_wr_en, mwb_wr_en;
  logic [1:0]  shift_mode;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs_idx(in_rs_idx), .in_rs_data(in_rs_data),
    .in_imm(in_imm), .in_rd(in_rd),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .shift_in(shift_in), .shift_val(shift_val), .shift_mode(shift_mode), .out_rd(out_rd)
  );

  typedef struct {
    logic [3:0]  op, rs_idx, imm, rd;
    logic [15:0] rs_data;
    logic        exm_en;
    logic [3:0]  exm_rd;
    logic [15:0] exm_data;
    logic        mwb_en;
    logic [3:0]  mwb_rd;
    logic [15:0] mwb_data;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [3:0]  exp_amt;
    logic [1:0]  exp_mode;
    logic [3:0]  exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_head(input string name, input logic [15:0] d, input logic [3:0] a,
                          input logic [1:0] m, input logic [3:0] r);
    chk({name, ".valid"}, {15'h0, out_valid}, 16'h1);
    chk({name, ".data"}, shift_in, d);
    chk({name, ".amt"}, {12'h0, shift_val}, {12'h0, a});
    chk({name, ".mode"}, {14'h0, shift_mode}, {14'h0, m});
    chk({name, ".rd"}, {12'h0, out_rd}, {12'h0, r});
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [15:0] d, input logic [3:0] imm,
                          input logic [3:0] rd);
    in_valid = 1'b1; in_opcode = op; in_rs_idx = 4'h1; in_rs_data = d; in_imm = imm; in_rd = rd;
    exm_wr_en = 1'b0; mwb_wr_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'h5, 4'h1, 4'h3, 4'h2, 16'h8001, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,
                1'b1, 16'h8001, 4'h3, 2'b01, 4'h2};
    vecs[1] = '{4'h4, 4'h3, 4'hF, 4'h7, 16'hAAAA, 1'b1, 4'h3, 16'h1234, 1'b1, 4'h3, 16'hFFFF,
                1'b1, FWD ? 16'h1234 : 16'hAAAA, 4'hF, 2'b00, 4'h7};
    vecs[2] = '{4'h6, 4'h0, 4'h1, 4'h4, 16'h5555, 1'b1, 4'h0, 16'h1234, 1'b1, 4'h0, 16'hFFFF,
                1'b1, 16'h5555, 4'h1, 2'b10, 4'h4};
    vecs[3] = '{4'h5, 4'h9, 4'h8, 4'h9, 16'h0F0F, 1'b1, 4'h8, 16'h1111, 1'b1, 4'h9, 16'hBEEF,
                1'b1, FWD ? 16'hBEEF : 16'h0F0F, 4'h8, 2'b01, 4'h9};
    vecs[4] = '{4'h0, 4'h1, 4'h2, 4'h3, 16'h7777, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,
                1'b0, 16'h0, 4'h0, 2'b00, 4'h0};
    vecs[5] = '{4'h4, 4'h2, 4'h5, 4'hA, 16'h0001, 1'b0, 4'h2, 16'h9999, 1'b0, 4'h2, 16'h8888,
                1'b1, 16'h0001, 4'h5, 2'b00, 4'hA};
    vecs[6] = '{4'h7, 4'h1, 4'h2, 4'h3, 16'h4444, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,
                1'b0, 16'h0, 4'h0, 2'b00, 4'h0};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_opcode = 4'h0; in_rs_idx = 4'h0; in_rs_data = 16'h0; in_imm = 4'h0; in_rd = 4'h0;
    exm_wr_en = 1'b0; exm_rd = 4'h0; exm_data = 16'h0;
    mwb_wr_en = 1'b0; mwb_rd = 4'h0; mwb_data = 16'h0;

    // Reset state
    #12;
    chk("rst.out_valid", {15'h0, out_valid}, 16'h0);
    chk("rst.in_ready", {15'h0, in_ready}, 16'h1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst.out_valid", {15'h0, out_valid}, 16'h0);
    chk("post_rst.in_ready", {15'h0, in_ready}, 16'h1);
    chk("post_rst.shift_in", shift_in, 16'h0000);
    chk("post_rst.shift_mode", {14'h0, shift_mode}, 16'h0);
    chk("post_rst.shift_val", {12'h0, shift_val}, 16'h0);
    chk("post_rst.out_rd", {12'h0, out_rd}, 16'h0);

    // Streaming vectors with out_ready high: each edge shows the newest shift op or empty
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_opcode = vecs[i].op; in_rs_idx = vecs[i].rs_idx;
      in_rs_data = vecs[i].rs_data; in_imm = vecs[i].imm; in_rd = vecs[i].rd;
      exm_wr_en = vecs[i].exm_en; exm_rd = vecs[i].exm_rd; exm_data = vecs[i].exm_data;
      mwb_wr_en = vecs[i].mwb_en; mwb_rd = vecs[i].mwb_rd; mwb_data = vecs[i].mwb_data;
      tick();
      chk($sformatf("vec%0d.in_ready", i), {15'h0, in_ready}, 16'h1);
      if (vecs[i].exp_valid)
        chk_head($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_amt,
                 vecs[i].exp_mode, vecs[i].exp_rd);
      else
        chk($sformatf("vec%0d.out_valid", i), {15'h0, out_valid}, 16'h0);
    end
    @(negedge clk) in_valid = 1'b0;
    tick();
    chk("drain.out_valid", {15'h0, out_valid}, 16'h0);

    // Back-pressure: A (ROR) then B (SLL) with out_ready low
    @(negedge clk) out_ready = 1'b0; drive_op(4'h6, 16'h00F0, 4'h4, 4'h5);
    tick();
    chk_head("bp.A_first", 16'h00F0, 4'h4, 2'b10, 4'h5);
    chk("bp.ready_after_A", {15'h0, in_ready}, 16'h1);
    @(negedge clk) drive_op(4'h4, 16'h0F00, 4'h1, 4'h6);
    tick();
    chk("bp.ready_after_B", {15'h0, in_ready}, 16'h0);
    @(negedge clk) in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_head($sformatf("bp.hold%0d", c), 16'h00F0, 4'h4, 2'b10, 4'h5);
      chk($sformatf("bp.hold%0d.in_ready", c), {15'h0, in_ready}, 16'h0);
    end
    @(negedge clk) out_ready = 1'b1;
    tick();
    chk_head("bp.B", 16'h0F00, 4'h1, 2'b00, 4'h6);
    chk("bp.ready_refill", {15'h0, in_ready}, 16'h1);
    tick();
    chk("bp.empty", {15'h0, out_valid}, 16'h0);

    // Flush with head and skid full and a shift op arriving
    @(negedge clk) out_ready = 1'b0; drive_op(4'h5, 16'h1111, 4'h2, 4'h1);
    tick();
    @(negedge clk) drive_op(4'h6, 16'h2222, 4'h3, 4'h2);
    tick();
    chk("fl.full_ready", {15'h0, in_ready}, 16'h0);
    @(negedge clk) flush = 1'b1; drive_op(4'h4, 16'h3333, 4'h4, 4'h3);
    tick();
    chk("fl.out_valid", {15'h0, out_valid}, 16'h0);
    chk("fl.in_ready", {15'h0, in_ready}, 16'h1);
    @(negedge clk) flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl.dropped", {15'h0, out_valid}, 16'h0);

    // Asynchronous reset in the middle of a cycle with entries held
    @(negedge clk) drive_op(4'h5, 16'h4321, 4'h7, 4'h8);
    tick();
    @(negedge clk) drive_op(4'h6, 16'h5678, 4'h1, 4'h9);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {15'h0, out_valid}, 16'h0);
    chk("arst.in_ready", {15'h0, in_ready}, 16'h1);
    chk("arst.shift_in", shift_in, 16'h0000);
    @(negedge clk) rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("arst.after", {15'h0, out_valid}, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
